// File: rtl/ysyx_22050612_pkg.sv
// Shared decode encodings for the ysyx_22050612 pipeline: opcodes, formats, op classes
// and the decoded-entry payload.
package ysyx_22050612_pkg;

  localparam int unsigned FMT_W = 3;
  localparam int unsigned CLS_W = 4;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  localparam logic [FMT_W-1:0] FMT_R = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J = 3'd5;

  localparam logic [CLS_W-1:0] CLS_ALU    = 4'd0;
  localparam logic [CLS_W-1:0] CLS_ALUW   = 4'd1;
  localparam logic [CLS_W-1:0] CLS_LOAD   = 4'd2;
  localparam logic [CLS_W-1:0] CLS_STORE  = 4'd3;
  localparam logic [CLS_W-1:0] CLS_BRANCH = 4'd4;
  localparam logic [CLS_W-1:0] CLS_JAL    = 4'd5;
  localparam logic [CLS_W-1:0] CLS_JALR   = 4'd6;
  localparam logic [CLS_W-1:0] CLS_LUI    = 4'd7;
  localparam logic [CLS_W-1:0] CLS_AUIPC  = 4'd8;
  localparam logic [CLS_W-1:0] CLS_SYS    = 4'd9;

  // Width-independent part of a decoded entry (PC and immediate are parameter sized).
  typedef struct packed {
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [FMT_W-1:0] fmt;
    logic [CLS_W-1:0] cls;
    logic             rd_wen;
    logic             illegal;
  } dec_t;

endpackage

// File: rtl/ysyx_22050612_idu_stage_imm_gen.sv
// Immediate generator: assembles the format-specific immediate and sign-extends to XLEN.
module ysyx_22050612_imm_gen
  import ysyx_22050612_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:7]      inst,
  input  logic [FMT_W-1:0] fmt,
  output logic [XLEN-1:0]  imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/ysyx_22050612_idu_stage.sv
// Registered RV32I/RV64I decode stage between IFU and EXU with valid/ready handshake,
// flush and a saturating decoded-instruction counter.
module ysyx_22050612_idu_stage
  import ysyx_22050612_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [3:0]       out_cls,
  output logic             out_rd_wen,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_cnt
);

  logic [FMT_W-1:0] fmt_d;
  logic [CLS_W-1:0] cls_d;
  logic             illegal_d;
  logic [XLEN-1:0]  imm_raw;
  logic             accept;
  dec_t             dec_d;
  dec_t             dec_q;
  logic [XLEN-1:0]  imm_q;

  // Opcode classification; illegal encodings collapse to an I/SYS entry so EXU can trap.
  always_comb begin
    fmt_d     = FMT_I;
    cls_d     = CLS_SYS;
    illegal_d = 1'b0;
    if (in_inst[1:0] != 2'b11) begin
      illegal_d = 1'b1;
    end else begin
      case (in_inst[6:0])
        OP_IMM:    begin fmt_d = FMT_I; cls_d = CLS_ALU;    end
        OP:        begin fmt_d = FMT_R; cls_d = CLS_ALU;    end
        LOAD:      begin fmt_d = FMT_I; cls_d = CLS_LOAD;   end
        STORE:     begin fmt_d = FMT_S; cls_d = CLS_STORE;  end
        BRANCH:    begin fmt_d = FMT_B; cls_d = CLS_BRANCH; end
        JAL:       begin fmt_d = FMT_J; cls_d = CLS_JAL;    end
        JALR:      begin fmt_d = FMT_I; cls_d = CLS_JALR;   end
        LUI:       begin fmt_d = FMT_U; cls_d = CLS_LUI;    end
        AUIPC:     begin fmt_d = FMT_U; cls_d = CLS_AUIPC;  end
        SYSTEM:    begin fmt_d = FMT_I; cls_d = CLS_SYS;    end
        OP_IMM_32: begin
          if (XLEN == 64) begin fmt_d = FMT_I; cls_d = CLS_ALUW; end
          else illegal_d = 1'b1;
        end
        OP_32: begin
          if (XLEN == 64) begin fmt_d = FMT_R; cls_d = CLS_ALUW; end
          else illegal_d = 1'b1;
        end
        default:   illegal_d = 1'b1;
      endcase
    end
    if (illegal_d) begin
      fmt_d = FMT_I;
      cls_d = CLS_SYS;
    end
  end

  ysyx_22050612_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (in_inst[31:7]),
    .fmt  (fmt_d),
    .imm  (imm_raw)
  );

  always_comb begin
    dec_d.rd      = in_inst[11:7];
    dec_d.rs1     = in_inst[19:15];
    dec_d.rs2     = in_inst[24:20];
    dec_d.funct3  = in_inst[14:12];
    dec_d.fmt     = fmt_d;
    dec_d.cls     = cls_d;
    dec_d.illegal = illegal_d;
    dec_d.rd_wen  = !illegal_d && (in_inst[11:7] != 5'd0) &&
                    (fmt_d == FMT_R || fmt_d == FMT_I || fmt_d == FMT_U || fmt_d == FMT_J);
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Pipeline register: rst > flush > accept; a drain clears only the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      imm_q     <= '0;
      dec_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      imm_q     <= illegal_d ? '0 : imm_raw;
      dec_q     <= dec_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt <= '0;
    end else if (accept && (dec_cnt != {CNT_W{1'b1}})) begin
      dec_cnt <= dec_cnt + CNT_W'(1);
    end
  end

  assign out_rd      = dec_q.rd;
  assign out_rs1     = dec_q.rs1;
  assign out_rs2     = dec_q.rs2;
  assign out_funct3  = dec_q.funct3;
  assign out_imm     = imm_q;
  assign out_fmt     = dec_q.fmt;
  assign out_cls     = dec_q.cls;
  assign out_rd_wen  = dec_q.rd_wen;
  assign out_illegal = dec_q.illegal;

endmodule

// File: tb/tb_ysyx_22050612_idu_stage.sv
// Directed bench for the decode stage: a default RV64 instance and an RV32/CNT_W=4
// instance share the same stimulus.
module tb_ysyx_22050612_idu_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid, a_rd_wen, a_illegal;
  logic [63:0] a_pc, a_imm;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_funct3, a_fmt;
  logic [3:0]  a_cls;
  logic [31:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_rd_wen, b_illegal;
  logic [31:0] b_pc, b_imm;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_funct3, b_fmt;
  logic [3:0]  b_cls;
  logic [3:0]  b_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ysyx_22050612_idu_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_funct3(a_funct3),
    .out_imm(a_imm), .out_fmt(a_fmt), .out_cls(a_cls), .out_rd_wen(a_rd_wen),
    .out_illegal(a_illegal), .dec_cnt(a_cnt)
  );

  ysyx_22050612_idu_stage #(.XLEN(32), .PC_W(32), .CNT_W(4)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_funct3(b_funct3),
    .out_imm(b_imm), .out_fmt(b_fmt), .out_cls(b_cls), .out_rd_wen(b_rd_wen),
    .out_illegal(b_illegal), .dec_cnt(b_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_pc = 64'h0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    in_inst = inst; in_pc = pc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", a_out_valid); end
    tests++; if (a_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", a_cnt); end
    tests++; if ({a_imm, a_rd, a_fmt, a_cls, a_pc} !== '0) begin fails++; $display("FAIL reset_fields got imm=%h rd=%0d fmt=%0d cls=%0d pc=%h want 0", a_imm, a_rd, a_fmt, a_cls, a_pc); end
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
  endtask

  task automatic test_itype();
    send(32'hFFF00093, 64'h8000_0000);
    tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL addi_valid got %b want 1", a_out_valid); end
    tests++; if ({a_fmt, a_cls, a_rd, a_rd_wen, a_illegal} !== {3'd1, 4'd0, 5'd1, 1'b1, 1'b0}) begin fails++; $display("FAIL addi_dec got fmt=%0d cls=%0d rd=%0d wen=%b ill=%b want 1 0 1 1 0", a_fmt, a_cls, a_rd, a_rd_wen, a_illegal); end
    tests++; if (a_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL addi_imm got %h want ffffffffffffffff", a_imm); end
    tests++; if (a_pc !== 64'h8000_0000) begin fails++; $display("FAIL addi_pc got %h want 80000000", a_pc); end
    step();
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL drain_valid got %b want 0", a_out_valid); end
    tests++; if (a_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL drain_keep got %h want ffffffffffffffff", a_imm); end
  endtask

  task automatic test_store_branch();
    send(32'h0020A423, 64'h4);
    tests++; if ({a_fmt, a_cls, a_rs1, a_rs2, a_funct3, a_rd_wen} !== {3'd2, 4'd3, 5'd1, 5'd2, 3'd2, 1'b0}) begin fails++; $display("FAIL sw_dec got fmt=%0d cls=%0d rs1=%0d rs2=%0d f3=%0d wen=%b want 2 3 1 2 2 0", a_fmt, a_cls, a_rs1, a_rs2, a_funct3, a_rd_wen); end
    tests++; if (a_imm !== 64'd8) begin fails++; $display("FAIL sw_imm got %h want 8", a_imm); end
    send(32'hFE000EE3, 64'h8);
    tests++; if ({a_fmt, a_cls, a_rd_wen} !== {3'd3, 4'd4, 1'b0}) begin fails++; $display("FAIL beq_dec got fmt=%0d cls=%0d wen=%b want 3 4 0", a_fmt, a_cls, a_rd_wen); end
    tests++; if (a_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL beq_imm got %h want fffffffffffffffc", a_imm); end
  endtask

  task automatic test_upper_jump();
    send(32'h800002B7, 64'hC);
    tests++; if ({a_fmt, a_cls, a_rd, a_rd_wen} !== {3'd4, 4'd7, 5'd5, 1'b1}) begin fails++; $display("FAIL lui_dec got fmt=%0d cls=%0d rd=%0d wen=%b want 4 7 5 1", a_fmt, a_cls, a_rd, a_rd_wen); end
    tests++; if (a_imm !== 64'hFFFF_FFFF_8000_0000) begin fails++; $display("FAIL lui_imm got %h want ffffffff80000000", a_imm); end
    tests++; if (b_imm !== 32'h8000_0000) begin fails++; $display("FAIL lui_imm32 got %h want 80000000", b_imm); end
    send(32'h001000EF, 64'h10);
    tests++; if ({a_fmt, a_cls, a_rd, a_rd_wen} !== {3'd5, 4'd5, 5'd1, 1'b1}) begin fails++; $display("FAIL jal_dec got fmt=%0d cls=%0d rd=%0d wen=%b want 5 5 1 1", a_fmt, a_cls, a_rd, a_rd_wen); end
    tests++; if (a_imm !== 64'h800) begin fails++; $display("FAIL jal_imm got %h want 800", a_imm); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    send(32'hFFF00093, 64'h100);
    in_inst = 32'h800002B7; in_pc = 64'h104; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc=%0d got %b want 0", i, a_in_ready); end
      step();
      tests++; if ({a_out_valid, a_rd, a_pc, a_imm} !== {1'b1, 5'd1, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF}) begin fails++; $display("FAIL bp_hold cyc=%0d got v=%b rd=%0d pc=%h imm=%h want 1 1 100 all-ones", i, a_out_valid, a_rd, a_pc, a_imm); end
    end
    tests++; if (a_cnt !== 32'd1) begin fails++; $display("FAIL bp_cnt_hold got %0d want 1", a_cnt); end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if ({a_out_valid, a_rd, a_pc, a_fmt} !== {1'b1, 5'd5, 64'h104, 3'd4}) begin fails++; $display("FAIL bp_release got v=%b rd=%0d pc=%h fmt=%0d want 1 5 104 4", a_out_valid, a_rd, a_pc, a_fmt); end
    tests++; if (a_cnt !== 32'd2) begin fails++; $display("FAIL bp_cnt got %0d want 2", a_cnt); end
    step();
    tests++; if ({a_out_valid, a_cnt} !== {1'b0, 32'd2}) begin fails++; $display("FAIL bp_nodup got v=%b cnt=%0d want 0 2", a_out_valid, a_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h0020A423, 64'h200);
    out_ready = 1'b1; flush = 1'b1;
    send(32'h001000EF, 64'h204);
    flush = 1'b0;
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b want 0", a_out_valid); end
    tests++; if (a_cnt !== 32'd3) begin fails++; $display("FAIL flush_cnt got %0d want 3", a_cnt); end
    tests++; if (a_pc !== 64'h200) begin fails++; $display("FAIL flush_drop got pc=%h want 200", a_pc); end
  endtask

  task automatic test_illegal();
    send(32'h0000_0000, 64'h300);
    tests++; if ({a_illegal, a_rd_wen, a_fmt, a_cls, a_imm} !== {1'b1, 1'b0, 3'd1, 4'd9, 64'h0}) begin fails++; $display("FAIL ill_zero got ill=%b wen=%b fmt=%0d cls=%0d imm=%h want 1 0 1 9 0", a_illegal, a_rd_wen, a_fmt, a_cls, a_imm); end
    tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL ill_flows got %b want 1", a_out_valid); end
    send(32'h0010009B, 64'h304);
    tests++; if ({a_illegal, a_cls, a_rd_wen, a_imm} !== {1'b0, 4'd1, 1'b1, 64'h1}) begin fails++; $display("FAIL addiw64 got ill=%b cls=%0d wen=%b imm=%h want 0 1 1 1", a_illegal, a_cls, a_rd_wen, a_imm); end
    tests++; if ({b_illegal, b_cls, b_rd_wen, b_imm} !== {1'b1, 4'd9, 1'b0, 32'h0}) begin fails++; $display("FAIL addiw32 got ill=%b cls=%0d wen=%b imm=%h want 1 9 0 0", b_illegal, b_cls, b_rd_wen, b_imm); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; in_inst = 32'hFFF00093;
    for (int i = 0; i < 16; i++) begin
      in_pc = 64'h1000 + 64'(i * 4);
      step();
      tests++; if ({a_out_valid, a_pc} !== {1'b1, 64'h1000 + 64'(i * 4)}) begin fails++; $display("FAIL b2b_pc i=%0d got v=%b pc=%h want 1 %h", i, a_out_valid, a_pc, 64'h1000 + 64'(i * 4)); end
      if (i == 13) begin
        tests++; if (b_cnt !== 4'd14) begin fails++; $display("FAIL cnt_pre_sat got %0d want 14", b_cnt); end
      end
    end
    in_valid = 1'b0;
    tests++; if (a_cnt !== 32'd16) begin fails++; $display("FAIL cnt_wide got %0d want 16", a_cnt); end
    tests++; if (b_cnt !== 4'd15) begin fails++; $display("FAIL cnt_sat got %0d want 15", b_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h800002B7, 64'h500);
    rst = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tests++; if ({a_out_valid, a_cnt, a_rd, a_imm, a_pc} !== '0) begin fails++; $display("FAIL rst_mid got v=%b cnt=%0d rd=%0d imm=%h pc=%h want 0", a_out_valid, a_cnt, a_rd, a_imm, a_pc); end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_store_branch();
    test_upper_jump();
    test_backpressure();
    test_flush();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
